// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and EX-forwarding control for a 5-stage MIPS pipeline, driven by
// a shadow scoreboard of the EX, MEM and WB slots, plus performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int CNT_W        = 32,
    parameter int BRANCH_STAGE = 3,
    parameter int FWD_EN       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_id_valid,
    input  logic [REG_AW-1:0] in_id_rs,
    input  logic [REG_AW-1:0] in_id_rt,
    input  logic              in_id_uses_rs,
    input  logic              in_id_uses_rt,
    input  logic              in_id_regwrite,
    input  logic              in_id_memread,
    input  logic [REG_AW-1:0] in_id_dst,
    input  logic              in_branch_taken,
    input  logic              in_cnt_clear,
    output logic              out_pc_write,
    output logic              out_ifid_write,
    output logic              out_flush_ifid,
    output logic              out_flush_idex,
    output logic              out_flush_exmem,
    output logic [1:0]        out_fwd_a,
    output logic [1:0]        out_fwd_b,
    output logic [CNT_W-1:0]  out_cycle_cnt,
    output logic [CNT_W-1:0]  out_retire_cnt,
    output logic [CNT_W-1:0]  out_stall_cnt,
    output logic [CNT_W-1:0]  out_flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memread;
        logic [REG_AW-1:0] dst;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rs;
        logic              uses_rt;
    } ex_slot_t;

    // MEM and WB are only ever consulted as writers, so they keep writer info only.
    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic [REG_AW-1:0] dst;
    } wr_slot_t;

    ex_slot_t ex_reg, ex_next;
    wr_slot_t mem_reg, mem_next;
    wr_slot_t wb_reg;

    logic [CNT_W-1:0] cycle_cnt_reg, retire_cnt_reg, stall_cnt_reg, flush_cnt_reg;

    logic ex_hit, mem_hit, hazard, br_slot_valid, br, stall;
    logic flush_idex, flush_exmem;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic writes(input logic valid, input logic regwrite,
                                    input logic [REG_AW-1:0] dst,
                                    input logic [REG_AW-1:0] r);
        return valid && regwrite && (dst != '0) && (dst == r);
    endfunction

    assign ex_hit  = (in_id_uses_rs && writes(ex_reg.valid, ex_reg.regwrite, ex_reg.dst, in_id_rs)) ||
                     (in_id_uses_rt && writes(ex_reg.valid, ex_reg.regwrite, ex_reg.dst, in_id_rt));
    assign mem_hit = (in_id_uses_rs && writes(mem_reg.valid, mem_reg.regwrite, mem_reg.dst, in_id_rs)) ||
                     (in_id_uses_rt && writes(mem_reg.valid, mem_reg.regwrite, mem_reg.dst, in_id_rt));

    // With forwarding only a load in EX cannot be bypassed in time.
    assign hazard = in_id_valid &&
                    ((FWD_EN != 0) ? (ex_reg.memread && ex_hit) : (ex_hit || mem_hit));

    assign br_slot_valid = (BRANCH_STAGE == 2) ? ex_reg.valid : mem_reg.valid;
    assign br            = in_branch_taken && br_slot_valid;
    assign stall         = hazard && !br;
    assign flush_idex    = stall || br;
    assign flush_exmem   = br && (BRANCH_STAGE == 3);

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if ((FWD_EN != 0) && ex_reg.valid) begin
            if (ex_reg.uses_rs && writes(mem_reg.valid, mem_reg.regwrite, mem_reg.dst, ex_reg.rs))
                fwd_a = 2'b10;
            else if (ex_reg.uses_rs && writes(wb_reg.valid, wb_reg.regwrite, wb_reg.dst, ex_reg.rs))
                fwd_a = 2'b01;
            if (ex_reg.uses_rt && writes(mem_reg.valid, mem_reg.regwrite, mem_reg.dst, ex_reg.rt))
                fwd_b = 2'b10;
            else if (ex_reg.uses_rt && writes(wb_reg.valid, wb_reg.regwrite, wb_reg.dst, ex_reg.rt))
                fwd_b = 2'b01;
        end
    end

    always_comb begin
        ex_next          = '0;
        ex_next.valid    = in_id_valid && !flush_idex;
        ex_next.regwrite = in_id_regwrite;
        ex_next.memread  = in_id_memread;
        ex_next.dst      = in_id_dst;
        ex_next.rs       = in_id_rs;
        ex_next.rt       = in_id_rt;
        ex_next.uses_rs  = in_id_uses_rs;
        ex_next.uses_rt  = in_id_uses_rt;
        mem_next         = '0;
        if (!flush_exmem) begin
            mem_next.valid    = ex_reg.valid;
            mem_next.regwrite = ex_reg.regwrite;
            mem_next.dst      = ex_reg.dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg  <= '0;
            mem_reg <= '0;
            wb_reg  <= '0;
        end else begin
            ex_reg  <= ex_next;
            mem_reg <= mem_next;
            wb_reg  <= mem_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
            flush_cnt_reg  <= '0;
        end else if (in_cnt_clear) begin
            cycle_cnt_reg  <= '0;
            retire_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            cycle_cnt_reg <= cycle_cnt_reg + CNT_ONE;
            if (wb_reg.valid) retire_cnt_reg <= retire_cnt_reg + CNT_ONE;
            if (stall)        stall_cnt_reg  <= stall_cnt_reg + CNT_ONE;
            if (br)           flush_cnt_reg  <= flush_cnt_reg + CNT_ONE;
        end
    end

    assign out_pc_write    = !stall;
    assign out_ifid_write  = !stall;
    assign out_flush_ifid  = br;
    assign out_flush_idex  = flush_idex;
    assign out_flush_exmem = flush_exmem;
    assign out_fwd_a       = fwd_a;
    assign out_fwd_b       = fwd_b;
    assign out_cycle_cnt   = cycle_cnt_reg;
    assign out_retire_cnt  = retire_cnt_reg;
    assign out_stall_cnt   = stall_cnt_reg;
    assign out_flush_cnt   = flush_cnt_reg;

endmodule
